// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot loader. Packs a byte stream little-endian into 32-bit words.
//            Writes each complete word to consecutive instruction-memory word
//            addresses. Holds the CPU in reset until the stream ends cleanly.
// Ports    : clock, reset (async, active-low)
//            start                    - one-cycle pulse; begins a load from
//                                       IDLE, DONE or ERROR
//            s_data/s_valid/s_last    - byte stream input
//            s_ready                  - byte stream backpressure
//            mem_we/mem_addr/mem_wdata - instruction-memory write port
//            word_count               - words written since start
//            cpu_hold, done, error    - status outputs
// Config   : PROGRAM_LOADER_CHECKSUM_EN - the final complete word must equal
//            the 32-bit sum of all earlier words. A mismatch, or a partial
//            final word, ends the load in ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] word_count,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] C_MAX_WORDS = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      final_state;    // destination after the last full word
    state_t      partial_state;  // destination when s_last cuts a word short

    logic [1:0]  idx;
    logic [23:0] lane_buf;       // lanes 0..2; lane 3 goes straight to mem_wdata
    logic [31:0] ptr;
    logic        last_pending;

    logic        accept;
    logic        overflow;
    logic        start_ok;

    assign accept   = s_valid && (state == S_RECV);
    assign overflow = accept && (word_count == C_MAX_WORDS);
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) ||
                                (state == S_ERROR));

    // Status outputs are pure state decodes. This keeps done/error sticky
    // until the next start, and cpu_hold low only while in DONE.
    assign s_ready  = (state == S_RECV);
    assign mem_we   = (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
    assign cpu_hold = (state != S_DONE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;

    // The accumulator holds the sum of every word written so far. While the
    // checksum word itself is in WRITE, csum_acc still excludes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_acc <= 32'h0;
        end else if (start_ok) begin
            csum_acc <= 32'h0;
        end else if (state == S_WRITE) begin
            csum_acc <= csum_acc + mem_wdata;
        end
    end

    assign final_state   = (mem_wdata == csum_acc) ? S_DONE : S_ERROR;
    assign partial_state = S_ERROR;
`else
    assign final_state   = S_DONE;
    assign partial_state = S_DONE;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    // Overflow wins: with no room left, even a terminating
                    // byte is treated as an abort.
                    if (overflow) begin
                        state_next = S_ERROR;
                    end else if (idx == 2'd3) begin
                        state_next = S_WRITE;
                    end else if (s_last) begin
                        state_next = partial_state;
                    end
                end
            end
            S_WRITE: begin
                state_next = last_pending ? final_state : S_RECV;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx          <= 2'd0;
            lane_buf     <= 24'h0;
            ptr          <= BASE_ADDR;
            last_pending <= 1'b0;
            word_count   <= 16'h0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
        end else begin
            if (start_ok) begin
                idx          <= 2'd0;
                ptr          <= BASE_ADDR;
                last_pending <= 1'b0;
                word_count   <= 16'h0;
            end

            if (accept && !overflow) begin
                idx <= idx + 2'd1;
                case (idx)
                    2'd0: lane_buf[7:0]   <= s_data;
                    2'd1: lane_buf[15:8]  <= s_data;
                    2'd2: lane_buf[23:16] <= s_data;
                    default: begin
                        // Present the word during the WRITE cycle that
                        // follows. Outside WRITE these registers hold.
                        mem_addr     <= ptr;
                        mem_wdata    <= {s_data, lane_buf};
                        last_pending <= s_last;
                    end
                endcase
            end

            if (state == S_WRITE) begin
                ptr        <= ptr + 32'd4;
                word_count <= word_count + 16'd1;
                idx        <= 2'd0;
            end
        end
    end

endmodule
`default_nettype wire
